// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_pkg
// Brief   : Shared constants and types for the video pixel feeder block.
// Revision: 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int PIXEL_W    = 24;
    localparam int DEF_WIDTH  = 800;
    localparam int DEF_HEIGHT = 600;
    localparam int DEF_STRIDE = 1024;
    localparam int ADDR_SHIFT = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/video_pixel_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : video_pixel_feeder_if
// Brief   : Memory read port and ready/valid pixel stream of the feeder.
// Revision: 1.0 - initial release
// ============================================================================
interface video_pixel_feeder_if;
    import video_pkg::*;

    logic [31:0]        rd_addr;
    logic               rd_valid;
    logic               rd_ready;
    logic [31:0]        rd_data;
    logic               rd_data_valid;
    logic [PIXEL_W-1:0] video;
    logic               video_valid;
    logic               video_ready;

    modport master (
        output rd_addr, rd_valid, video, video_valid,
        input  rd_ready, rd_data, rd_data_valid, video_ready
    );

    modport slave (
        input  rd_addr, rd_valid, video, video_valid,
        output rd_ready, rd_data, rd_data_valid, video_ready
    );

endinterface
`default_nettype wire

// File: rtl/video_pixel_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pixel_fifo
// Brief   : First-word-fall-through FIFO with exported fill count.
// Revision: 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 24
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     push,
    input  wire  [DATA_W-1:0]       push_data,
    input  wire                     pop,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/video_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module  : video_pixel_feeder
// Brief   : Fetches frame-buffer pixels from memory and streams them to DVI.
// Revision: 1.0 - initial release
// ============================================================================
module video_pixel_feeder
    import video_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int FIFO_DEPTH = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire  [31:0]          frame_base,
    input  wire                  frame_base_valid,
    video_pixel_feeder_if.master bus,
    output logic                 frame_interrupt,
    output logic                 underflow
);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int          SUM_W     = CNT_W + 1;
    localparam logic [15:0] X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST    = 16'(HEIGHT - 1);
    localparam logic [31:0] LINE_STEP = 32'(STRIDE) << ADDR_SHIFT;
    localparam logic [31:0] PIX_STEP  = 32'(1) << ADDR_SHIFT;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_pend_base;
    logic [31:0]        r_line_addr;
    logic [31:0]        r_rd_addr;
    logic               r_rd_valid;
    logic [15:0]        r_req_x, r_req_y;
    logic [15:0]        r_out_x, r_out_y;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_out_next, w_cnt_next, w_fifo_count;
    logic [SUM_W-1:0]   w_credit_sum;
    logic [PIXEL_W-1:0] w_head;
    logic [31:0]        w_new_base;
    logic               w_run, w_fire, w_push, w_pop, w_fifo_empty;
    logic               w_unused_rd_bits;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (frame_base_valid) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_run  = (r_state == ST_RUN);
    assign w_fire = r_rd_valid && bus.rd_ready;
    assign w_push = w_run && bus.rd_data_valid;
    assign w_pop  = !w_fifo_empty && bus.video_ready;

    // rd_valid is registered, so the credit test is evaluated on next-cycle counts.
    assign w_out_next   = r_outstanding + CNT_W'(w_fire) - CNT_W'(w_push);
    assign w_cnt_next   = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_credit_sum = SUM_W'(w_out_next) + SUM_W'(w_cnt_next);

    // A base write landing on the last-request wrap must steer the new frame.
    assign w_new_base = frame_base_valid ? frame_base : r_pend_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pend_base     <= '0;
            r_line_addr     <= '0;
            r_rd_addr       <= '0;
            r_rd_valid      <= 1'b0;
            r_req_x         <= '0;
            r_req_y         <= '0;
            r_out_x         <= '0;
            r_out_y         <= '0;
            r_outstanding   <= '0;
            frame_interrupt <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            r_rd_valid    <= (w_state_next == ST_RUN) && (w_credit_sum < SUM_W'(FIFO_DEPTH));

            if (!w_run) begin
                if (frame_base_valid) begin
                    r_pend_base <= frame_base;
                    r_line_addr <= frame_base;
                    r_rd_addr   <= frame_base;
                end
            end else begin
                if (frame_base_valid) r_pend_base <= frame_base;
                if (w_fire) begin
                    if (r_req_x == X_LAST) begin
                        r_req_x <= '0;
                        if (r_req_y == Y_LAST) begin
                            r_req_y     <= '0;
                            r_line_addr <= w_new_base;
                            r_rd_addr   <= w_new_base;
                        end else begin
                            r_req_y     <= r_req_y + 16'd1;
                            r_line_addr <= r_line_addr + LINE_STEP;
                            r_rd_addr   <= r_line_addr + LINE_STEP;
                        end
                    end else begin
                        r_req_x   <= r_req_x + 16'd1;
                        r_rd_addr <= r_rd_addr + PIX_STEP;
                    end
                end
            end

            frame_interrupt <= 1'b0;
            if (w_pop) begin
                if (r_out_x == X_LAST) begin
                    r_out_x <= '0;
                    if (r_out_y == Y_LAST) begin
                        r_out_y         <= '0;
                        frame_interrupt <= 1'b1;
                    end else begin
                        r_out_y <= r_out_y + 16'd1;
                    end
                end else begin
                    r_out_x <= r_out_x + 16'd1;
                end
            end

            if (w_run && bus.video_ready && w_fifo_empty) underflow <= 1'b1;
        end
    end

    pixel_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PIXEL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (bus.rd_data[PIXEL_W-1:0]),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    assign bus.rd_addr     = r_rd_addr;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.video       = w_head;
    assign bus.video_valid = !w_fifo_empty;

    assign w_unused_rd_bits = ^bus.rd_data[31:PIXEL_W];

endmodule
`default_nettype wire

// File: tb/tb_video_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_pixel_feeder
// Brief   : Directed self-checking bench for video_pixel_feeder (4x2, stride 8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_video_pixel_feeder;
    import video_pkg::*;

    typedef struct {
        logic        wr_en;
        logic [31:0] wr_base;
        logic [31:0] exp_addr;
        logic [23:0] exp_video;
    } vec_t;

    typedef struct {
        int          due;
        logic [23:0] data;
    } mem_t;

    localparam int NVEC = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] frame_base = '0;
    logic        frame_base_valid = 1'b0;
    logic        frame_interrupt;
    logic        underflow;

    video_pixel_feeder_if bus();

    video_pixel_feeder #(
        .WIDTH      (4),
        .HEIGHT     (2),
        .STRIDE     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_base       (frame_base),
        .frame_base_valid (frame_base_valid),
        .bus              (bus),
        .frame_interrupt  (frame_interrupt),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          seq = 0;
    int          mem_lat = 1;
    bit          rdy_rand = 0;
    bit          rdy_val = 1;
    bit          vr_toggle = 0;
    bit          vr_val = 0;
    bit          hold = 0;
    logic [23:0] hold_val = '0;
    int          stab_err = 0;
    mem_t        mq[$];
    logic [31:0] addr_q[$];
    logic [23:0] pop_q[$];
    int          popc_q[$];
    int          fi_q[$];
    vec_t        tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: posedge, then drive memory/ready inputs and log handshakes at negedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        bus.video_ready = vr_toggle ? ~bus.video_ready : vr_val;
        bus.rd_data_valid = 1'b0;
        bus.rd_data = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data = {8'hA5, mq[0].data};
            void'(mq.pop_front());
        end
        if (bus.rd_valid && bus.rd_ready) begin
            addr_q.push_back(bus.rd_addr);
            mq.push_back('{due: cyc + mem_lat, data: 24'(seq)});
            seq++;
        end
        if (bus.video_valid && bus.video_ready) begin
            pop_q.push_back(bus.video);
            popc_q.push_back(cyc);
        end
        if (hold && !(bus.video_valid && bus.video == hold_val)) stab_err++;
        hold = bus.video_valid && !bus.video_ready;
        hold_val = bus.video;
        if (frame_interrupt) fi_q.push_back(cyc);
    endtask

    task automatic clear_logs();
        mq.delete();
        addr_q.delete();
        pop_q.delete();
        popc_q.delete();
        fi_q.delete();
        seq = 0;
        hold = 0;
        stab_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_base_valid = 1'b0;
        mq.delete();
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_video_valid"}, 32'(bus.video_valid), 0);
        check({tag, "_video"}, 32'(bus.video), 0);
        check({tag, "_frame_int"}, 32'(frame_interrupt), 0);
        check({tag, "_underflow"}, 32'(underflow), 0);
    endtask

    initial begin
        logic [31:0] offs [8];
        logic [31:0] fbase [4];
        int          errs;

        offs  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h20, 32'h24, 32'h28, 32'h2C};
        fbase = '{32'h1000, 32'h1000, 32'h2000, 32'h5000};
        for (int i = 0; i < NVEC; i++)
            tbl[i] = '{wr_en: 1'b0, wr_base: '0, exp_addr: fbase[i/8] + offs[i%8], exp_video: 24'(i)};
        tbl[10].wr_en = 1'b1; tbl[10].wr_base = 32'h2000;
        tbl[23].wr_en = 1'b1; tbl[23].wr_base = 32'h5000;

        bus.rd_ready = 1'b0;
        bus.rd_data = '0;
        bus.rd_data_valid = 1'b0;
        bus.video_ready = 1'b0;

        // ---- Reset state, base sequence, data order, interrupt ----
        do_reset();
        check_idle("reset");
        rdy_val = 1; vr_val = 1; mem_lat = 1;
        frame_base = 32'h1000;
        frame_base_valid = 1'b1;
        tick();
        frame_base_valid = 1'b0;
        check("first_rd_valid", 32'(bus.rd_valid), 1);
        check("first_rd_addr", bus.rd_addr, 32'h1000);
        for (int k = 0; k < 600 && pop_q.size() < NVEC; k++) begin
            tick();
            frame_base_valid = 1'b0;
            for (int i = 0; i < NVEC; i++)
                if (tbl[i].wr_en && bus.rd_valid && bus.rd_ready && addr_q.size() == i + 1) begin
                    frame_base = tbl[i].wr_base;
                    frame_base_valid = 1'b1;
                end
        end
        frame_base_valid = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("addr[%0d]", i), (i < addr_q.size()) ? addr_q[i] : 32'hDEADBEEF, tbl[i].exp_addr);
            check($sformatf("video[%0d]", i), (i < pop_q.size()) ? 32'(pop_q[i]) : 32'hDEADBEEF, 32'(tbl[i].exp_video));
        end
        check("frame_int_count", fi_q.size(), 3);
        for (int j = 0; j < 3; j++)
            check($sformatf("frame_int_cycle[%0d]", j),
                  (j < fi_q.size()) ? 32'(fi_q[j]) : 32'hFFFFFFFF,
                  (8*j + 7 < popc_q.size()) ? 32'(popc_q[8*j + 7] + 1) : 32'hFFFFFFFE);

        // ---- Credits: no pops, 1-cycle memory ----
        do_reset();
        rdy_val = 1; vr_val = 0; mem_lat = 1;
        frame_base = 32'h1000;
        frame_base_valid = 1'b1;
        tick();
        frame_base_valid = 1'b0;
        repeat (20) tick();
        check("credit_requests", addr_q.size(), 4);
        check("credit_rd_valid", 32'(bus.rd_valid), 0);
        check("credit_video_valid", 32'(bus.video_valid), 1);
        check("credit_head", 32'(bus.video), 0);
        vr_val = 1;
        tick();
        vr_val = 0;
        repeat (10) tick();
        check("credit_pops", pop_q.size(), 1);
        check("credit_refill", addr_q.size(), 5);
        check("credit_rd_valid2", 32'(bus.rd_valid), 0);
        check("credit_head2", 32'(bus.video), 1);
        check("credit_underflow", 32'(underflow), 0);

        // ---- Backpressure: toggling video_ready, random rd_ready ----
        do_reset();
        rdy_rand = 1; vr_toggle = 1; mem_lat = 2;
        frame_base = 32'h1000;
        frame_base_valid = 1'b1;
        tick();
        frame_base_valid = 1'b0;
        for (int k = 0; k < 2000 && pop_q.size() < 24; k++) tick();
        errs = 0;
        for (int i = 0; i < 24; i++)
            if (i >= pop_q.size() || pop_q[i] !== 24'(i)) errs++;
        check("bp_done", 32'(pop_q.size() >= 24), 1);
        check("bp_order_errors", errs, 0);
        check("bp_stability_errors", stab_err, 0);
        rdy_rand = 0; vr_toggle = 0;

        // ---- Underflow, mid-frame reset, restart ----
        do_reset();
        rdy_val = 1; vr_val = 1; mem_lat = 10;
        frame_base = 32'h3000;
        frame_base_valid = 1'b1;
        tick();
        frame_base_valid = 1'b0;
        repeat (4) tick();
        check("uf_set", 32'(underflow), 1);
        check("uf_no_data_yet", 32'(bus.video_valid), 0);
        repeat (20) tick();
        check("uf_sticky", 32'(underflow), 1);
        check("uf_data_flowing", 32'(pop_q.size() > 0), 1);
        rst = 1'b1;
        mq.delete();
        tick();
        mq.delete();
        check_idle("rst_mid");
        rst = 1'b0;
        clear_logs();
        repeat (8) tick();
        check("idle_no_requests", addr_q.size(), 0);
        check("idle_rd_valid", 32'(bus.rd_valid), 0);
        check("idle_no_underflow", 32'(underflow), 0);
        bus.rd_data_valid = 1'b1;
        bus.rd_data = 32'h0000_0077;
        tick();
        check("idle_ignores_data", 32'(bus.video_valid), 0);
        frame_base = 32'h4000;
        frame_base_valid = 1'b1;
        tick();
        frame_base_valid = 1'b0;
        check("restart_rd_valid", 32'(bus.rd_valid), 1);
        check("restart_rd_addr", bus.rd_addr, 32'h4000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
